// File: rtl/snoop_bus_ctrl_pkg.sv
// Shared types for the snooping bus controller: transaction codes, bus
// broadcast message layout and the controller state encoding.
package types;

    localparam int NUM_CPUS = 4;
    localparam int XLEN     = 32;
    localparam int SRC_W    = 8;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2
    } bus_tx_t;

    typedef struct packed {
        logic             valid;
        logic [SRC_W-1:0] source;
        logic [XLEN-1:0]  addr;
        bus_tx_t          bus_tx;
    } bus_msg_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BCAST = 3'd1,
        SNOOP = 3'd2,
        MEM   = 3'd3,
        DONE  = 3'd4
    } snoop_state_t;

    // Reads that no cache satisfied must be filled from memory; upgrades never are.
    function automatic logic needs_mem(input bus_tx_t tx);
        return (tx == BUS_RD) || (tx == BUS_RDX);
    endfunction

endpackage

// File: rtl/snoop_bus_ctrl_arb.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping
// around, and returns it both one-hot and as an index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid                 = 1'b1;
                gnt[cand[IDX_W-1:0]]  = 1'b1;
                idx                   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snooping bus controller: grants one agent, broadcasts its transaction, collects
// snoop responses from every other agent and goes to memory only when needed.
module snoop_bus_ctrl
    import types::*;
#(
    parameter int NUM_AGENTS    = NUM_CPUS,
    parameter int ADDR_W        = XLEN,
    parameter int SNOOP_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_AGENTS-1:0] req,
    input  logic [ADDR_W-1:0]     req_addr [NUM_AGENTS],
    input  bus_tx_t               req_tx   [NUM_AGENTS],
    output logic [NUM_AGENTS-1:0] gnt,
    output bus_msg_t              bus_msg,
    input  logic [NUM_AGENTS-1:0] snoop_ack,
    input  logic [NUM_AGENTS-1:0] snoop_shared,
    input  logic [NUM_AGENTS-1:0] snoop_dirty,
    output logic                  mem_req,
    input  logic                  mem_ack,
    output logic [NUM_AGENTS-1:0] done,
    output logic                  done_shared,
    output logic                  done_dirty,
    output logic                  done_err,
    output snoop_state_t          fsm_state
);

    // Handshake: req is a level held by the agent; gnt rises the cycle after the
    // win and stays up through DONE; done pulses once, and gnt drops in the
    // following cycle. Dropping req after the grant does not abort the transaction.

    localparam int         IDX_W       = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;
    localparam logic [7:0] TIMEOUT_CNT = 8'(SNOOP_TIMEOUT);

    snoop_state_t          state, state_next;
    logic [NUM_AGENTS-1:0] src_mask;
    logic [IDX_W-1:0]      src_idx;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      ptr_next;
    logic [ADDR_W-1:0]     lat_addr;
    bus_tx_t               lat_tx;
    logic [NUM_AGENTS-1:0] acked;
    logic                  shared_acc;
    logic                  dirty_acc;
    logic                  err_q;
    logic [7:0]            cnt;

    logic [NUM_AGENTS-1:0] arb_gnt;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_valid;

    logic [NUM_AGENTS-1:0] new_ack;
    logic [NUM_AGENTS-1:0] acked_next;
    logic                  shared_next;
    logic                  dirty_next;
    logic                  all_acked;
    logic                  timeout;
    logic [7:0]            cnt_inc;

    rr_arbiter #(
        .N     (NUM_AGENTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // This cycle's acks are folded in before deciding, so an ack landing on the
    // timeout cycle still completes the snoop.
    always_comb begin
        new_ack     = snoop_ack & ~src_mask & ~acked;
        acked_next  = acked | new_ack;
        shared_next = shared_acc | (|(new_ack & snoop_shared));
        dirty_next  = dirty_acc | (|(new_ack & snoop_dirty));
        all_acked   = &(acked_next | src_mask);
        cnt_inc     = cnt + 8'd1;
        timeout     = (cnt_inc >= TIMEOUT_CNT);
        ptr_next    = (src_idx == IDX_W'(NUM_AGENTS - 1)) ? '0 : src_idx + IDX_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_next = BCAST;
                end
            end
            BCAST: state_next = SNOOP;
            SNOOP: begin
                if (all_acked) begin
                    if (dirty_next) begin
                        state_next = DONE;
                    end else if (needs_mem(lat_tx)) begin
                        state_next = MEM;
                    end else begin
                        state_next = DONE;
                    end
                end else if (timeout) begin
                    state_next = DONE;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_mask   <= '0;
            src_idx    <= '0;
            rr_ptr     <= '0;
            lat_addr   <= '0;
            lat_tx     <= BUS_RD;
            acked      <= '0;
            shared_acc <= 1'b0;
            dirty_acc  <= 1'b0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        src_mask   <= arb_gnt;
                        src_idx    <= arb_idx;
                        lat_addr   <= req_addr[arb_idx];
                        lat_tx     <= req_tx[arb_idx];
                        acked      <= '0;
                        shared_acc <= 1'b0;
                        dirty_acc  <= 1'b0;
                        err_q      <= 1'b0;
                    end
                end
                SNOOP: begin
                    acked      <= acked_next;
                    shared_acc <= shared_next;
                    dirty_acc  <= dirty_next;
                    cnt        <= (state_next == SNOOP) ? cnt_inc : 8'd0;
                    if (timeout && !all_acked) begin
                        err_q <= 1'b1;
                    end
                end
                DONE: begin
                    src_mask <= '0;
                    rr_ptr   <= ptr_next;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt         = src_mask;
        bus_msg     = '0;
        mem_req     = 1'b0;
        done        = '0;
        done_shared = 1'b0;
        done_dirty  = 1'b0;
        done_err    = 1'b0;
        case (state)
            BCAST: begin
                bus_msg.valid  = 1'b1;
                bus_msg.source = SRC_W'(src_idx);
                bus_msg.addr   = XLEN'(lat_addr);
                bus_msg.bus_tx = lat_tx;
            end
            MEM: mem_req = 1'b1;
            DONE: begin
                done        = src_mask;
                done_shared = shared_acc;
                done_dirty  = dirty_acc;
                done_err    = err_q;
            end
            default: ;
        endcase
    end

    assign fsm_state = state;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_msg_in_bcast: assert property (@(posedge clk) disable iff (rst) bus_msg.valid |-> (state == BCAST));
    a_done_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(done));

endmodule
